// File: rtl/exe_stage.sv
// Execute stage: ALU, HI/LO with MULT and a 32-step restoring divider, exception detection, data-SRAM requests.
// Define EXE_DIV_FAST_EN to let trivial divides (|dividend| < |divisor| or divisor 0) finish in one cycle.
module exe_stage #(
   parameter int DIV_CYCLES = 32,
   parameter int DS_TO_ES_W = 221,
   parameter int ES_TO_MS_W = 112,
   parameter int ES_FWD_W   = 39
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  ms_allowin,
   output logic                  es_allowin,
   input  logic [DS_TO_ES_W-1:0] ds_to_es_bus,
   output logic [ES_TO_MS_W-1:0] es_to_ms_bus,
   output logic [ES_FWD_W-1:0]   es_forward_bus,
   input  logic                  ms_ex,
   input  logic [1:0]            pipeline_flush,
   output logic                  data_sram_en,
   output logic [3:0]            data_sram_wen,
   output logic [31:0]           data_sram_addr,
   output logic [31:0]           data_sram_wdata
);
   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLT = 4'd2, ALU_SLTU = 4'd3,
                          ALU_AND = 4'd4, ALU_OR = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7,
                          ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11;
   localparam logic [2:0] MD_MULT = 3'd1, MD_MULTU = 3'd2, MD_DIV = 3'd3, MD_DIVU = 3'd4,
                          MD_MTHI = 3'd5, MD_MTLO = 3'd6;
   localparam logic [2:0] LD_LH = 3'd3, LD_LHU = 3'd4, LD_LW = 3'd5;
   localparam logic [1:0] ST_SB = 2'd1, ST_SH = 2'd2, ST_SW = 2'd3;
   localparam logic [4:0] EXC_ADEL = 5'h04, EXC_ADES = 5'h05, EXC_OV = 5'h0c;

   typedef enum logic [1:0] {DIV_IDLE = 2'd0, DIV_BUSY = 2'd1, DIV_DONE = 2'd2} div_state_t;

   logic                  es_valid_reg;
   logic [DS_TO_ES_W-2:0] es_bus_reg;
   logic [3:0]  alu_op;
   logic        alu_ov, mf_hi, mf_lo, op_mfc0, rf_we, in_ex;
   logic [31:0] src1, src2, rs_value, rt_value, pc, in_badvaddr;
   logic [2:0]  md_op, load_op;
   logic [1:0]  store_op;
   logic [4:0]  dest, in_excode;

   // Field order (MSB first, after the valid bit) is shared with the decode stage.
   assign {alu_op, alu_ov, src1, src2, rs_value, rt_value, md_op, mf_hi, mf_lo, load_op,
           store_op, op_mfc0, dest, rf_we, pc, in_ex, in_excode, in_badvaddr} = es_bus_reg;

   logic flush, es_ready_go, handshake, es_ex;
   logic [4:0]  es_excode;
   logic [31:0] es_badvaddr, alu_result, es_result, add_res, sub_res;
   logic [31:0] hi_reg, lo_reg;

   assign flush = pipeline_flush[1] | pipeline_flush[0];

   // ALU
   assign add_res = src1 + src2;
   assign sub_res = src1 - src2;
   always_comb begin
      alu_result = add_res;
      case (alu_op)
         ALU_SUB:  alu_result = sub_res;
         ALU_SLT:  alu_result = {31'd0, $signed(src1) < $signed(src2)};
         ALU_SLTU: alu_result = {31'd0, src1 < src2};
         ALU_AND:  alu_result = src1 & src2;
         ALU_OR:   alu_result = src1 | src2;
         ALU_XOR:  alu_result = src1 ^ src2;
         ALU_NOR:  alu_result = ~(src1 | src2);
         ALU_SLL:  alu_result = src2 << src1[4:0];
         ALU_SRL:  alu_result = src2 >> src1[4:0];
         ALU_SRA:  alu_result = 32'($signed(src2) >>> src1[4:0]);
         ALU_LUI:  alu_result = {src2[15:0], 16'd0};
         default:  alu_result = add_res;
      endcase
   end

   logic add_ovf, sub_ovf, ov_ex, adel_ex, ades_ex, is_load, is_store;
   assign add_ovf  = (src1[31] == src2[31]) && (add_res[31] != src1[31]);
   assign sub_ovf  = (src1[31] != src2[31]) && (sub_res[31] != src1[31]);
   assign ov_ex    = alu_ov && (((alu_op == ALU_ADD) && add_ovf) || ((alu_op == ALU_SUB) && sub_ovf));
   assign is_load  = load_op != 3'd0;
   assign is_store = store_op != 2'd0;
   assign adel_ex  = ((load_op == LD_LW) && (add_res[1:0] != 2'b00)) ||
                     (((load_op == LD_LH) || (load_op == LD_LHU)) && add_res[0]);
   assign ades_ex  = ((store_op == ST_SW) && (add_res[1:0] != 2'b00)) ||
                     ((store_op == ST_SH) && add_res[0]);

   always_comb begin
      es_ex       = 1'b1;
      es_excode   = in_excode;
      es_badvaddr = in_badvaddr;
      if (in_ex) begin
         es_ex = 1'b1;
      end else if (ov_ex) begin
         es_excode = EXC_OV;
      end else if (adel_ex) begin
         es_excode   = EXC_ADEL;
         es_badvaddr = add_res;
      end else if (ades_ex) begin
         es_excode   = EXC_ADES;
         es_badvaddr = add_res;
      end else begin
         es_ex = 1'b0;
      end
   end

   // Divider: acc holds {remainder, quotient}; dividend bits shift out of the low half.
   div_state_t  div_state_reg, div_state_next;
   logic [4:0]  div_cnt_reg;
   logic [63:0] div_acc_reg, div_step;
   logic [31:0] divisor_reg, dividend_abs, divisor_abs, div_quo, div_rem;
   logic [32:0] div_top;
   logic        quo_neg_reg, rem_neg_reg, is_div, div_signed, div_start;

   assign is_div       = (md_op == MD_DIV) || (md_op == MD_DIVU);
   assign div_signed   = md_op == MD_DIV;
   assign dividend_abs = (div_signed && src1[31]) ? -src1 : src1;
   assign divisor_abs  = (div_signed && src2[31]) ? -src2 : src2;
   assign div_start    = es_valid_reg && is_div && !es_ex && !flush;
   assign div_top      = div_acc_reg[63:31];
   assign div_step     = (div_top >= {1'b0, divisor_reg}) ?
                         {div_top[31:0] - divisor_reg, div_acc_reg[30:0], 1'b1} :
                         {div_acc_reg[62:0], 1'b0};
   assign div_quo      = quo_neg_reg ? -div_acc_reg[31:0] : div_acc_reg[31:0];
   assign div_rem      = rem_neg_reg ? -div_acc_reg[63:32] : div_acc_reg[63:32];
`ifdef EXE_DIV_FAST_EN
   logic div_early;
   assign div_early = (dividend_abs < divisor_abs) || (divisor_abs == 32'd0);
`endif

   always_comb begin
      div_state_next = div_state_reg;
      if (flush) begin
         div_state_next = DIV_IDLE;
      end else begin
         case (div_state_reg)
            DIV_IDLE:
               if (div_start) begin
`ifdef EXE_DIV_FAST_EN
                  div_state_next = div_early ? DIV_DONE : DIV_BUSY;
`else
                  div_state_next = DIV_BUSY;
`endif
               end
            DIV_BUSY: if (div_cnt_reg == 5'(DIV_CYCLES - 1)) div_state_next = DIV_DONE;
            DIV_DONE: if (es_valid_reg && ms_allowin) div_state_next = DIV_IDLE;
            default:  div_state_next = DIV_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) div_state_reg <= DIV_IDLE;
      else         div_state_reg <= div_state_next;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_cnt_reg <= 5'd0;
         div_acc_reg <= 64'd0;
         divisor_reg <= 32'd0;
         quo_neg_reg <= 1'b0;
         rem_neg_reg <= 1'b0;
      end else if ((div_state_reg == DIV_IDLE) && div_start) begin
         div_cnt_reg <= 5'd0;
         divisor_reg <= divisor_abs;
         quo_neg_reg <= div_signed && (src1[31] != src2[31]);
         rem_neg_reg <= div_signed && src1[31];
`ifdef EXE_DIV_FAST_EN
         // Early exit preloads what the full iteration would have produced.
         if (divisor_abs == 32'd0)  div_acc_reg <= {dividend_abs, 32'hffff_ffff};
         else if (div_early)        div_acc_reg <= {dividend_abs, 32'd0};
         else                       div_acc_reg <= {32'd0, dividend_abs};
`else
         div_acc_reg <= {32'd0, dividend_abs};
`endif
      end else if (div_state_reg == DIV_BUSY) begin
         div_acc_reg <= div_step;
         div_cnt_reg <= div_cnt_reg + 5'd1;
      end
   end

   // Handshake and stage valid
   assign es_ready_go = !(es_valid_reg && is_div && !es_ex) || (div_state_reg == DIV_DONE);
   assign es_allowin  = !es_valid_reg || (es_ready_go && ms_allowin);
   assign handshake   = es_valid_reg && es_ready_go && ms_allowin;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         es_valid_reg <= 1'b0;
         es_bus_reg   <= '0;
      end else begin
         if (flush)           es_valid_reg <= 1'b0;
         else if (es_allowin) es_valid_reg <= ds_to_es_bus[DS_TO_ES_W-1];
         if (es_allowin && ds_to_es_bus[DS_TO_ES_W-1]) es_bus_reg <= ds_to_es_bus[DS_TO_ES_W-2:0];
      end
   end

   // HI/LO commit only when the instruction is certain to retire.
   logic signed [63:0] smul;
   logic        [63:0] umul;
   logic               hilo_we;
   assign smul    = $signed({{32{src1[31]}}, src1}) * $signed({{32{src2[31]}}, src2});
   assign umul    = {32'd0, src1} * {32'd0, src2};
   assign hilo_we = handshake && !es_ex && !ms_ex && !flush;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hi_reg <= 32'd0;
         lo_reg <= 32'd0;
      end else if (hilo_we) begin
         case (md_op)
            MD_MULT:         {hi_reg, lo_reg} <= smul;
            MD_MULTU:        {hi_reg, lo_reg} <= umul;
            MD_DIV, MD_DIVU: {hi_reg, lo_reg} <= {div_rem, div_quo};
            MD_MTHI:         hi_reg <= rs_value;
            MD_MTLO:         lo_reg <= rs_value;
            default:         ;
         endcase
      end
   end

   assign es_result = mf_hi ? hi_reg : (mf_lo ? lo_reg : alu_result);

   // Data SRAM request
   logic [3:0] wmask;
   always_comb begin
      wmask = 4'b0000;
      case (store_op)
         ST_SB:   wmask = 4'b0001 << add_res[1:0];
         ST_SH:   wmask = add_res[1] ? 4'b1100 : 4'b0011;
         ST_SW:   wmask = 4'b1111;
         default: wmask = 4'b0000;
      endcase
   end

   assign data_sram_en   = es_valid_reg && (is_load || is_store) && !es_ex && !ms_ex && !flush && ms_allowin;
   assign data_sram_wen  = (data_sram_en && is_store) ? wmask : 4'b0000;
   assign data_sram_addr = add_res;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_wdata
         assign data_sram_wdata[gi*8 +: 8] = (store_op == ST_SB) ? rt_value[7:0] :
                                             (store_op == ST_SH) ? rt_value[(gi%2)*8 +: 8] :
                                                                   rt_value[gi*8 +: 8];
      end
   endgenerate

   assign es_to_ms_bus = {es_valid_reg && es_ready_go, es_result, dest, rf_we && !es_ex, load_op,
                          pc, es_ex, es_excode, es_badvaddr};
   assign es_forward_bus = {es_valid_reg && is_load, es_valid_reg && op_mfc0,
                            (es_valid_reg && rf_we && !es_ex) ? dest : 5'd0, es_result};
endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: divider latency/results, HI/LO, exceptions, SRAM strobes, flush and async reset.
module tb_exe_stage;
   logic         clk = 1'b0, resetn = 1'b0, ms_allowin = 1'b1, ms_ex = 1'b0;
   logic [1:0]   pipeline_flush = 2'b00;
   logic [220:0] ds_to_es_bus = '0;
   logic         es_allowin, data_sram_en;
   logic [111:0] es_to_ms_bus;
   logic [38:0]  es_forward_bus;
   logic [3:0]   data_sram_wen;
   logic [31:0]  data_sram_addr, data_sram_wdata;

   exe_stage dut (
      .clk(clk), .resetn(resetn), .ms_allowin(ms_allowin), .es_allowin(es_allowin),
      .ds_to_es_bus(ds_to_es_bus), .es_to_ms_bus(es_to_ms_bus), .es_forward_bus(es_forward_bus),
      .ms_ex(ms_ex), .pipeline_flush(pipeline_flush), .data_sram_en(data_sram_en),
      .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata)
   );

   always #5 clk = ~clk;

   logic        o_valid, o_rf_we, o_ex, f_load, f_mfc0;
   logic [31:0] o_result, o_pc, o_badvaddr, f_result;
   logic [4:0]  o_dest, o_excode, f_dest;
   logic [2:0]  o_load_op;
   assign {o_valid, o_result, o_dest, o_rf_we, o_load_op, o_pc, o_ex, o_excode, o_badvaddr} = es_to_ms_bus;
   assign {f_load, f_mfc0, f_dest, f_result} = es_forward_bus;

   localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1;
   localparam logic [2:0] M_NONE = 3'd0, M_MULT = 3'd1, M_MULTU = 3'd2, M_DIV = 3'd3, M_DIVU = 3'd4;
   localparam logic [2:0] L_NONE = 3'd0, L_LW = 3'd5;
   localparam logic [1:0] S_NONE = 2'd0, S_SB = 2'd1, S_SH = 2'd2;

   int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
   int lat;
   logic allow_seen;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [220:0] mk(input logic [3:0] aop, input logic aov, input logic [31:0] s1,
                                       input logic [31:0] s2, input logic [31:0] rs, input logic [31:0] rt,
                                       input logic [2:0] md, input logic mfh, input logic mfl,
                                       input logic [2:0] ld, input logic [1:0] st, input logic [4:0] dst,
                                       input logic we);
      return {1'b1, aop, aov, s1, s2, rs, rt, md, mfh, mfl, ld, st, 1'b0, dst, we,
              32'hbfc0_0100, 1'b0, 5'd0, 32'd0};
   endfunction

   function automatic logic [220:0] op_mfhi();
      return mk(A_ADD, 1'b0, 0, 0, 0, 0, M_NONE, 1'b1, 1'b0, L_NONE, S_NONE, 5'd2, 1'b1);
   endfunction
   function automatic logic [220:0] op_mflo();
      return mk(A_ADD, 1'b0, 0, 0, 0, 0, M_NONE, 1'b0, 1'b1, L_NONE, S_NONE, 5'd3, 1'b1);
   endfunction
   function automatic logic [220:0] op_md(input logic [2:0] md, input logic [31:0] a, input logic [31:0] b);
      return mk(A_ADD, 1'b0, a, b, 0, 0, md, 1'b0, 1'b0, L_NONE, S_NONE, 5'd0, 1'b0);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [220:0] b);
      int n = 0;
      while (!es_allowin && n < 200) begin
         step();
         n++;
      end
      if (!es_allowin) check("issue_allowin", es_allowin, 1'b1);
      ds_to_es_bus = b;
      step();
      ds_to_es_bus = '0;
   endtask

   task automatic wait_valid(output int n, output logic seen);
      n = 0;
      seen = 1'b0;
      while (!o_valid && n < 100) begin
         if (es_allowin) seen = 1'b1;
         step();
         n++;
      end
   endtask

   initial begin
      #12;
      check("rst_valid", o_valid, 1'b0);
      check("rst_sram_en", data_sram_en, 1'b0);
      check("rst_sram_wen", data_sram_wen, 4'd0);
      check("rst_fwd_dest", f_dest, 5'd0);
      check("rst_allowin", es_allowin, 1'b1);
      check("rst_hi", dut.hi_reg, 32'd0);
      resetn = 1'b1;
      step();

      // DIVU 100/7
      issue(op_md(M_DIVU, 32'd100, 32'd7));
      check("divu_first_valid", o_valid, 1'b0);
      wait_valid(lat, allow_seen);
      check("divu_latency", lat, 33);
      check("divu_allowin_busy", allow_seen, 1'b0);
      issue(op_mflo());
      check("divu_lo", f_result, 32'd14);
      check("divu_lo_ms", o_result, 32'd14);
      issue(op_mfhi());
      check("divu_hi", f_result, 32'd2);

      // DIV -7/2
      issue(op_md(M_DIV, 32'hffff_fff9, 32'd2));
      wait_valid(lat, allow_seen);
      check("div_latency", lat, 33);
      issue(op_mflo());
      check("div_lo_fwd", f_result, 32'hffff_fffd);
      check("div_mflo_dest", f_dest, 5'd3);
      issue(op_mfhi());
      check("div_hi", f_result, 32'hffff_ffff);

      // Flush during BUSY cycle 10
      issue(op_md(M_DIV, 32'd50, 32'd5));
      repeat (10) step();
      check("flush_busy_state", dut.div_state_reg, 2'd1);
      pipeline_flush = 2'b10;
      step();
      pipeline_flush = 2'b00;
      check("flush_state_idle", dut.div_state_reg, 2'd0);
      check("flush_valid", o_valid, 1'b0);
      check("flush_allowin", es_allowin, 1'b1);
      issue(op_mflo());
      check("flush_lo_kept", f_result, 32'hffff_fffd);
      issue(op_mfhi());
      check("flush_hi_kept", f_result, 32'hffff_ffff);

      // Overflow and plain ALU
      issue(mk(A_ADD, 1'b1, 32'h7fff_ffff, 32'd1, 0, 0, M_NONE, 1'b0, 1'b0, L_NONE, S_NONE, 5'd5, 1'b1));
      check("ov_valid", o_valid, 1'b1);
      check("ov_ex", o_ex, 1'b1);
      check("ov_excode", o_excode, 5'h0c);
      check("ov_rf_we", o_rf_we, 1'b0);
      check("ov_fwd_dest", f_dest, 5'd0);
      issue(mk(A_ADD, 1'b0, 32'h7fff_ffff, 32'd1, 0, 0, M_NONE, 1'b0, 1'b0, L_NONE, S_NONE, 5'd5, 1'b1));
      check("addu_ex", o_ex, 1'b0);
      check("addu_result", o_result, 32'h8000_0000);
      check("addu_fwd_dest", f_dest, 5'd5);
      issue(mk(A_SUB, 1'b1, 32'd5, 32'd7, 0, 0, M_NONE, 1'b0, 1'b0, L_NONE, S_NONE, 5'd6, 1'b1));
      check("sub_result", o_result, 32'hffff_fffe);
      check("sub_ex", o_ex, 1'b0);

      // MULT with ms_ex leaves HI/LO alone
      issue(op_md(M_MULT, 32'h0001_0000, 32'h0001_0000));
      ms_ex = 1'b1;
      issue(op_mfhi());
      ms_ex = 1'b0;
      check("mult_msex_hi", f_result, 32'hffff_ffff);
      issue(op_mflo());
      check("mult_msex_lo", f_result, 32'hffff_fffd);
      issue(op_md(M_MULTU, 32'h0001_0000, 32'h0001_0000));
      issue(op_mfhi());
      check("multu_hi", f_result, 32'd1);
      issue(op_mflo());
      check("multu_lo", f_result, 32'd0);
      issue(op_md(M_MULT, 32'hffff_fffe, 32'd3));
      issue(op_mfhi());
      check("mult_neg_hi", f_result, 32'hffff_ffff);
      issue(op_mflo());
      check("mult_neg_lo", f_result, 32'hffff_fffa);

      // Loads and stores
      issue(mk(A_ADD, 1'b0, 32'h1000, 32'd2, 0, 0, M_NONE, 1'b0, 1'b0, L_LW, S_NONE, 5'd4, 1'b1));
      check("lw_mis_ex", o_ex, 1'b1);
      check("lw_mis_excode", o_excode, 5'h04);
      check("lw_mis_badvaddr", o_badvaddr, 32'h1002);
      check("lw_mis_sram_en", data_sram_en, 1'b0);
      check("lw_mis_rf_we", o_rf_we, 1'b0);
      issue(mk(A_ADD, 1'b0, 32'h1000, 32'd4, 0, 0, M_NONE, 1'b0, 1'b0, L_LW, S_NONE, 5'd4, 1'b1));
      check("lw_sram_en", data_sram_en, 1'b1);
      check("lw_sram_addr", data_sram_addr, 32'h1004);
      check("lw_sram_wen", data_sram_wen, 4'b0000);
      check("lw_fwd_load", f_load, 1'b1);
      issue(mk(A_ADD, 1'b0, 32'h1000, 32'd3, 0, 32'h1234_56ab, M_NONE, 1'b0, 1'b0, L_NONE, S_SB, 5'd0, 1'b0));
      check("sb_sram_en", data_sram_en, 1'b1);
      check("sb_wen", data_sram_wen, 4'b1000);
      check("sb_wdata", data_sram_wdata, 32'habab_abab);
      issue(mk(A_ADD, 1'b0, 32'h1000, 32'd1, 0, 32'hcafe_beef, M_NONE, 1'b0, 1'b0, L_NONE, S_SH, 5'd0, 1'b0));
      check("sh_mis_excode", o_excode, 5'h05);
      check("sh_mis_sram_en", data_sram_en, 1'b0);
      issue(mk(A_ADD, 1'b0, 32'h1000, 32'd2, 0, 32'hcafe_beef, M_NONE, 1'b0, 1'b0, L_NONE, S_SH, 5'd0, 1'b0));
      check("sh_wen", data_sram_wen, 4'b1100);
      check("sh_wdata", data_sram_wdata, 32'hbeef_beef);
      step();

      // Async reset mid-BUSY
      issue(op_md(M_DIVU, 32'd1000, 32'd3));
      repeat (5) step();
      #3;
      resetn = 1'b0;
      #1;
      check("arst_valid", o_valid, 1'b0);
      check("arst_state", dut.div_state_reg, 2'd0);
      check("arst_hi", dut.hi_reg, 32'd0);
      check("arst_lo", dut.lo_reg, 32'd0);
      check("arst_allowin", es_allowin, 1'b1);
      #2;
      resetn = 1'b1;
      step();

      // DIVU 3/9
      issue(op_md(M_DIVU, 32'd3, 32'd9));
      wait_valid(lat, allow_seen);
`ifdef EXE_DIV_FAST_EN
      check("divu_small_latency", lat, 1);
`else
      check("divu_small_latency", lat, 33);
`endif
      issue(op_mflo());
      check("divu_small_lo", f_result, 32'd0);
      issue(op_mfhi());
      check("divu_small_hi", f_result, 32'd3);
      step();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline, between the decode stage and the memory stage.
- Consumes ds_to_es_bus and computes the ALU result.
- Owns HI/LO and an iterative 32-cycle radix-2 divider, detects OV/ADEL/ADES, and issues data-SRAM requests.
- Publishes es_forward_bus for decode-stage forwarding and stalling.

Parameters:
- DIV_CYCLES, 32, number of divider iterations (one quotient bit per cycle); only 32 is supported.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- ms_allowin  in  1  memory stage can accept
- es_allowin  out  1  execute stage can accept
- ds_to_es_bus  in  ds_to_es_bus_t  decoded instruction, operands, pc, exception; carries valid
- es_to_ms_bus  out  es_to_ms_bus_t  valid, result, dest, rf_we, load_op, pc, exception
- es_forward_bus  out  es_forward_bus_t  op_load, op_mfc0, dest, result
- ms_ex  in  1  memory/writeback stage holds an exception or eret; suppresses side effects here
- pipeline_flush  in  pipeline_flush_t  ex/eret flush
- data_sram_en  out  1  SRAM access strobe
- data_sram_wen  out  4  byte write enables
- data_sram_addr  out  32  byte address
- data_sram_wdata  out  32  store data, byte-replicated per store_op

Behaviour:
- Reset (resetn=0, async) values:
  - es_valid=0, div_state=IDLE, div_cnt=0, HI=0, LO=0.
  - All outputs derived from es_valid are low; data_sram_en=0, data_sram_wen=0.
- Handshake:
  - es_allowin = !es_valid || (es_ready_go && ms_allowin).
  - On es_allowin: es_valid <= ds_to_es_bus.valid; the bus is latched when valid.
  - es_to_ms_bus.valid = es_valid && es_ready_go.
  - A flush (ex|eret) clears es_valid next edge and overrides allowin.
- es_ready_go is 1 except for a valid, exception-free DIV/DIVU. For that case it is 1 only in div_state DONE.
- Divider FSM:
  - IDLE -> BUSY when es_valid, op is div, no exception, not flushing.
    - Latches |dividend|, |divisor| and sign info; div_cnt=0.
  - BUSY: one restoring shift-subtract step per cycle; div_cnt++. Goes to DONE when div_cnt reaches 31, i.e. 32 BUSY cycles.
  - DONE -> IDLE on the handshake (es_valid && ms_allowin). DONE holds otherwise.
  - Flush in any state -> IDLE next edge; HI/LO untouched.
  - Latency from the first cycle in stage to es_ready_go: 33 cycles.
  - Signed results: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - Divide by zero (no trap): quotient=0xFFFFFFFF, remainder=dividend for DIVU; the signed case follows the same raw datapath with sign fix.
- MULT/MULTU: single-cycle 64-bit product. HI=upper 32 bits, LO=lower 32 bits.
- HI/LO write commits only on the handshake edge, with no exception in this stage, ms_ex=0, and no flush.
  - MTHI/MTLO write rs_value.
  - MFHI/MFLO select HI/LO as the result.
- Exceptions:
  - An incoming exception has priority.
  - Otherwise OV when alu_ov and signed add/sub overflow.
  - Otherwise ADEL for LW misaligned (addr[1:0]!=0) or LH/LHU misaligned (addr[0]), with badvaddr=addr.
  - Otherwise ADES for the same store cases.
  - Exception implies rf_we=0 on the output bus.
- SRAM:
  - data_sram_en = es_valid && (load|store) && !es_ex && !ms_ex && !flush && ms_allowin.
  - wen nonzero only for stores, shifted by addr[1:0] (SB 1 byte, SH 2 bytes, SW 4 bytes).
  - data_sram_addr is the ALU sum.
- Forward bus:
  - dest = 0 unless es_valid && rf_we && !es_ex.
  - op_load/op_mfc0 are gated by es_valid.
  - result = ALU/HI/LO mux output.

Optional Feature:
- Macro EXE_DIV_FAST_EN.
- Defined:
  - IDLE goes directly to DONE (one cycle) when |dividend| < |divisor| or divisor==0.
  - Results are the same as the full iteration: quotient 0 and remainder=dividend, or the divide-by-zero values.
- Undefined: every divide takes the full 32 BUSY cycles.

Test Plan:
- DIVU 100/7, ms_allowin=1 -> es_to_ms valid 33 cycles after entry; LO=14, HI=2; es_allowin=0 throughout BUSY.
- DIV -7/2 then MFLO/MFHI -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; forwarded result of MFLO=0xFFFFFFFD.
- DIV issued, pipeline_flush.ex asserted at BUSY cycle 10 -> div_state IDLE next edge; HI/LO keep prior values; es_valid=0.
- ADD 0x7FFFFFFF+1 with alu_ov -> exception OV, rf_we=0, forward dest=0; MULT 0x10000 x 0x10000 with ms_ex=1 -> HI/LO unchanged.
- LW addr 0x1002 -> ADEL, badvaddr=0x1002, data_sram_en=0; SB addr 0x1003 data 0xAB -> wen=4'b1000, wdata=0xABABABAB.
- Async reset mid-BUSY (resetn low 3 ns off-edge) -> es_valid=0, HI=LO=0 immediately; with EXE_DIV_FAST_EN, DIVU 3/9 -> DONE after 1 cycle, LO=0, HI=3.
